// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b, one NIB-bit lookahead slice per clock.
// Optional macro NIBSUB_SATURATE_EN floors diff to zero whenever a borrow occurs.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int NIB   = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic [1:0]       dbg_state
);

  localparam int STEPS = WIDTH / NIB;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if ((WIDTH % NIB) != 0 || WIDTH < NIB) begin : g_bad_width
    $error("nibble_serial_subtractor: WIDTH must be a non-zero multiple of NIB");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // in_ready is high only in IDLE, out_valid only in DONE, both are state-derived.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_q, borrow_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [NIB-1:0]    a_nib, nb_nib, g, p, sum;
  logic [NIB:0]      c;
  logic              cl, pp;
  logic [WIDTH-1:0]  work_full;

  // Lookahead slice: every carry is a flat sum-of-products of g/p and carry_q.
  always_comb begin
    a_nib  = a_q[int'(cnt_q)*NIB +: NIB];
    nb_nib = ~b_q[int'(cnt_q)*NIB +: NIB];
    g      = a_nib & nb_nib;
    p      = a_nib | nb_nib;
    c      = '0;
    cl     = 1'b0;
    pp     = 1'b0;
    c[0]   = carry_q;
    for (int i = 0; i < NIB; i++) begin
      cl = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        cl = cl | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = cl | (pp & carry_q);
    end
    sum = a_nib ^ nb_nib ^ c[NIB-1:0];
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    work_d    = work_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    work_full = work_q;
    work_full[int'(cnt_q)*NIB +: NIB] = sum;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        work_d  = work_full;
        carry_d = c[NIB];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) begin
          borrow_d = ~c[NIB];
`ifdef NIBSUB_SATURATE_EN
          diff_d   = c[NIB] ? work_full : '0;
`else
          diff_d   = work_full;
`endif
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    diff      = diff_q;
    borrow    = borrow_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor: random and directed operations checked every cycle
// against an arithmetic reference with cycle-count timing from the accept edge.
module tb_nibble_serial_subtractor;
  localparam int W     = 16;
  localparam int STEPS = 4;

  logic         clk;
  logic         nrst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  nibble_serial_subtractor #(.WIDTH(W), .NIB(4)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    logic         br;
    br = (x < y);
    d  = x - y;
`ifdef NIBSUB_SATURATE_EN
    if (br) d = '0;
`endif
    return {br, d};
  endfunction

  // scoreboard / reference model, updated at negedge with the inputs the next edge will see
  logic [W:0] exp_q[$];
  logic [W:0] shown = '0;
  bit         shown_loaded = 0;
  bit         inflight = 0;
  bit         mon_en = 0;
  bit         exp_ov;
  int         cyc = 0;
  int         acc_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_ov = inflight && (cyc >= acc_cyc + STEPS);
    if (mon_en) begin
      if (exp_ov && !shown_loaded) begin
        if (exp_q.size() > 0) shown = exp_q.pop_front();
        shown_loaded = 1;
      end
      check("mon_in_ready", 32'(in_ready), 32'(!inflight));
      check("mon_out_valid", 32'(out_valid), 32'(exp_ov));
      check("mon_diff", 32'(diff), 32'(shown[W-1:0]));
      check("mon_borrow", 32'(borrow), 32'(shown[W]));
    end
    if (!nrst) begin
      inflight = 0;
      shown = '0;
      shown_loaded = 0;
      exp_q.delete();
      mon_en = 1;
    end else if (!inflight && in_valid) begin
      inflight = 1;
      acc_cyc = cyc + 1;
      exp_q.push_back(ref_sub(a, b));
      shown_loaded = 0;
    end else if (exp_ov && out_ready) begin
      inflight = 0;
    end
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input int hold,
                        input bit pulse, input bit lit, input logic [W-1:0] ed, input bit eb);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (n >= 20) check("wait_in_ready_timeout", 32'(in_ready), 32'd1);
    a = ta; b = tb_op; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    lat = 0;
    if (pulse) begin
      tick(); lat++;
      a = ~ta; b = ta; in_valid = 1'b1;
      tick(); lat++;
      in_valid = 1'b0;
    end
    while (!out_valid && lat < 20) begin tick(); lat++; end
    if (lat >= 20) check("wait_out_valid_timeout", 32'(out_valid), 32'd1);
    if (lit) begin
      check("latency", 32'(lat), 32'(STEPS));
      check("lit_diff", 32'(diff), 32'(ed));
      check("lit_borrow", 32'(borrow), 32'(eb));
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      if (lit) begin
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_diff", 32'(diff), 32'(ed));
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ready_after_consume", 32'(in_ready), 32'd1);
  endtask

  logic [W-1:0] ra, rb, sat_ff, sat_one;

  initial begin
    nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    nrst = 1'b1;
    tick();

`ifdef NIBSUB_SATURATE_EN
    sat_ff = 16'h0000; sat_one = 16'h0000;
`else
    sat_ff = 16'hFFFF; sat_one = 16'h0001;
`endif
    run_op(16'h1234, 16'h0234, 0, 0, 1, 16'h1000, 1'b0);
    run_op(16'h0000, 16'h0001, 0, 0, 1, sat_ff, 1'b1);
    run_op(16'h8000, 16'h0001, 0, 0, 1, 16'h7FFF, 1'b0);
    run_op(16'hA5A5, 16'hA5A5, 0, 0, 1, 16'h0000, 1'b0);
    run_op(16'h0000, 16'hFFFF, 0, 0, 1, sat_one, 1'b1);
    run_op(16'h5678, 16'h1111, 10, 0, 1, 16'h4567, 1'b0);
    run_op(16'h0F00, 16'h00F1, 0, 1, 1, 16'h0E0F, 1'b0);

    // reset during the second busy cycle
    a = 16'h4321; b = 16'h1234; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    nrst = 1'b0;
    tick();
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_borrow", 32'(borrow), 32'd0);
    nrst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_no_out_valid", 32'(out_valid), 32'd0);
    end

    // randomized operations with boundary bias and random backpressure
    for (int k = 0; k < 60; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: begin ra = '0; rb = '1; end
        2: rb = ra + W'(1);
        default: ;
      endcase
      run_op(ra, rb, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 0, '0, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
